bcd_event_counter: RTL
======================

Name: bcd_event_counter

Overview:
- Eight-digit BCD up/down event counter that drives the eight 4-bit digit inputs (seg7..seg0) of the multiplexed seven-segment display controller.
- Counts either debounced push-button presses or an internal periodic tick.
- Sits directly upstream of the display controller, on the same board clock.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before the synchronised button level is accepted (minimum 2).
- TICK_DIV, 10000000: clock cycles per auto-count tick (minimum 2).

Ports:
- clk  input  1  board clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- step_in  input  1  raw, bouncy, asynchronous push-button; high = pressed.
- up  input  1  direction; 1 = increment, 0 = decrement; sampled on the count cycle.
- clr  input  1  synchronous clear of all digits; level-sensitive.
- hold  input  1  freezes the count while high.
- auto_en  input  1  enables the periodic tick source.
- seg7..seg0  output  4 each  BCD digits, seg7 most significant; registered.
- wrap  output  1  one-cycle pulse when the count wraps in either direction.

Behaviour:
- Reset (reset=0, asynchronous):
  - seg7..seg0 = 0, wrap = 0.
  - Synchroniser flops, debounced level, debounce counter, tick counter and edge register all cleared.
- Synchroniser: step_in passes through two flops to give s_sync.
- Debounce:
  - Counter runs while s_sync != db_level; it clears whenever they match.
  - db_level toggles at the edge where the counter reaches DEBOUNCE_CYCLES-1, and the counter clears at that edge.
- Step pulse:
  - step_pulse = db_level & ~db_level_d, where db_level_d is db_level delayed one cycle.
  - One pulse per accepted press; release produces no pulse.
- Tick source:
  - While auto_en=1, the tick counter counts 0..TICK_DIV-1 and tick_pulse=1 on the cycle the counter equals TICK_DIV-1.
  - auto_en=0 clears the counter, so re-enabling gives the first tick TICK_DIV cycles later.
- Count event: cnt_ev = (step_pulse | tick_pulse) & ~hold.
  - Coincident step and tick events count once.
  - Events arriving during hold are discarded, not queued.
  - Debouncer and tick counter keep running during hold.
- Priority: clr > cnt_ev.
  - clr=1 sets all digits to 0 at the next edge and suppresses wrap.
- Increment (up=1, cnt_ev=1):
  - Digit i becomes (digit i + 1) if digit i < 9, else 0.
  - Digit i changes only if all lower digits equal 9 (carry chain).
- Decrement (up=0, cnt_ev=1):
  - Digit i becomes (digit i - 1) if digit i > 0, else 9.
  - Digit i changes only if all lower digits equal 0.
- Wrap:
  - 99999999 +1 gives 00000000, and wrap=1 in the same cycle the digits update.
  - 00000000 -1 gives 99999999, and wrap=1.
  - wrap=0 otherwise.
- Latency:
  - Digits update at the clock edge ending the cycle in which cnt_ev=1.
  - From the first stable step_in sample: 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) edges to the digit change.
- Outputs never hold non-BCD values (A–F), including immediately after reset or clr.
- Reset asserted mid-debounce or mid-tick abandons that operation; no pulse is generated after release.
- up changes between events take effect on the next event only.

Decomposition:
- Shared package (display_pkg): NUM_DIGITS=8, BCD_MAX=4'd9, BCD_MIN=4'd0, digit width 4.
- Sub-module button_debounce: contains the synchroniser, debounce counter and rising-edge pulse.
  - Ports: clk, reset, raw_in, level_out, pulse_out; parameter DEBOUNCE_CYCLES.
  - Reusable for other board buttons.
- Tick counter and BCD chain remain in bcd_event_counter.

Test Plan:
Simulate with DEBOUNCE_CYCLES=4 and TICK_DIV=10.
1. Reset and release reset; up=1; step_in held high 20 cycles with no bounce -> exactly one increment (seg0=1, others 0) on edge 7 after the first high sample; wrap=0.
2. Bounce rejection: step_in toggles every 2 cycles for 16 cycles, then stays high -> no count during toggling, then exactly one increment.
3. auto_en=1, up=1, count preloaded to 00000098 via repeated ticks -> after 10 cycles 00000099, after 20 cycles 00000100; carry ripples correctly.
4. Wrap: count 99999999, one step pulse with up=1 -> 00000000 with a 1-cycle wrap pulse. Then up=0 and one pulse -> 99999999 with wrap=1.
5. Priority and hold:
   - clr=1 coincident with tick -> 00000000, wrap=0.
   - hold=1 across two ticks and a press -> digits unchanged.
   - Step pulse and tick in the same cycle -> +1 only.
6. Async reset: assert reset=0 mid-debounce with count 00001234 -> all digits 0 immediately, without waiting for a clock edge. After release, a held step_in needs the full 2+4+1 edges before counting.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the BCD counter and the seven-segment display path.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t BCD_MAX = 4'd9;
  localparam digit_t BCD_MIN = 4'd0;

  // Any out-of-range input steps back into 0..9, so a corrupted digit self-heals.
  function automatic digit_t bcd_step(input digit_t d, input logic up);
    if (up) begin
      return (d >= BCD_MAX) ? BCD_MIN : digit_t'(d + 4'd1);
    end
    return (d == BCD_MIN || d > BCD_MAX) ? BCD_MAX : digit_t'(d - 4'd1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, stability-counting debouncer and rising-edge pulse
// for a raw mechanical push-button.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic pulse_out
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  // Counter only advances while the synchronised input disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= raw_in;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level_out = r_level;
  assign pulse_out = r_level & ~r_level_d;

endmodule

// File: rtl/bcd_event_counter.sv
// Eight-digit BCD up/down counter fed by a debounced button or a periodic
// tick; drives the digit inputs of the seven-segment display controller.
module bcd_event_counter
  import display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TICK_DIV        = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_in,
  input  logic       up,
  input  logic       clr,
  input  logic       hold,
  input  logic       auto_en,
  output logic [3:0] seg7,
  output logic [3:0] seg6,
  output logic [3:0] seg5,
  output logic [3:0] seg4,
  output logic [3:0] seg3,
  output logic [3:0] seg2,
  output logic [3:0] seg1,
  output logic [3:0] seg0,
  output logic       wrap
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic                                r_wrap;
  logic [TICK_W-1:0]                   r_tick_cnt;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_digits;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_next;
  logic                                w_step_pulse;
  logic                                w_tick_pulse;
  logic                                w_cnt_ev;
  logic                                w_wrap_cond;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .raw_in   (step_in),
    .level_out(),
    .pulse_out(w_step_pulse)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
    end else if (!auto_en || r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign w_tick_pulse = auto_en && (r_tick_cnt == TICK_LAST);
  assign w_cnt_ev     = (w_step_pulse | w_tick_pulse) & ~hold;

  // Ripple carry/borrow: a digit moves only while every lower digit sits at
  // its terminal value; a carry out of the top digit is the wrap condition.
  always_comb begin
    logic carry;
    w_next = r_digits;
    carry  = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        w_next[i] = bcd_step(r_digits[i], up);
      end
      carry = carry & (up ? (r_digits[i] == BCD_MAX) : (r_digits[i] == BCD_MIN));
    end
    w_wrap_cond = carry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digits <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (clr) begin
        r_digits <= '0;
      end else if (w_cnt_ev) begin
        r_digits <= w_next;
        r_wrap   <= w_wrap_cond;
      end
    end
  end

  assign seg0 = r_digits[0];
  assign seg1 = r_digits[1];
  assign seg2 = r_digits[2];
  assign seg3 = r_digits[3];
  assign seg4 = r_digits[4];
  assign seg5 = r_digits[5];
  assign seg6 = r_digits[6];
  assign seg7 = r_digits[7];
  assign wrap = r_wrap;

endmodule
